// File: rtl/perm_gen_ctrl.sv
// perm_gen_ctrl: builds a 256-entry byte permutation from a chaotic byte stream.
// Define PERM_FALLBACK_FILL_EN to append unused values when the draw budget runs out.
module perm_gen_ctrl #(
  parameter int unsigned MAX_DRAWS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        chaos_valid,
  input  logic [7:0]  chaos_data,
  output logic        chaos_ready,
  output logic        perm_we,
  output logic [7:0]  perm_addr,
  output logic [7:0]  perm_data,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [15:0] dup_count,
  output logic [15:0] draw_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_FILL,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [255:0]  used_q;
  logic [8:0]    idx_q;
  logic          we_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          fail_q;
  logic [15:0]   dup_q;
  logic [15:0]   draw_q;
`ifdef PERM_FALLBACK_FILL_EN
  logic [7:0]    s_q;
`endif

  logic is_new;
  logic last_slot;
  logic budget_hit;

  assign is_new     = ~used_q[chaos_data];
  assign last_slot  = (idx_q == 9'd255);
  // This accept is the MAX_DRAWS-th one.
  assign budget_hit = ({1'b0, draw_q} + 17'd1) == 17'(MAX_DRAWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      fail_q  <= 1'b0;
      dup_q   <= '0;
      draw_q  <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          used_q  <= '0;
          idx_q   <= '0;
          dup_q   <= '0;
          draw_q  <= '0;
          fail_q  <= 1'b0;
`ifdef PERM_FALLBACK_FILL_EN
          s_q     <= '0;
`endif
          state_q <= S_COLLECT;
        end
        S_COLLECT: begin
          if (chaos_valid) begin
            draw_q <= draw_q + 16'd1;
            if (is_new) begin
              used_q[chaos_data] <= 1'b1;
              we_q   <= 1'b1;
              addr_q <= idx_q[7:0];
              data_q <= chaos_data;
              idx_q  <= idx_q + 9'd1;
            end else if (dup_q != 16'hFFFF) begin
              dup_q <= dup_q + 16'd1;
            end
            if (is_new && last_slot) begin
              state_q <= S_DONE;
            end else if (budget_hit) begin
`ifdef PERM_FALLBACK_FILL_EN
              state_q <= S_FILL;
`else
              state_q <= S_DONE;
              fail_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef PERM_FALLBACK_FILL_EN
        S_FILL: begin
          if (!used_q[s_q]) begin
            used_q[s_q] <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= idx_q[7:0];
            data_q <= s_q;
            idx_q  <= idx_q + 9'd1;
            if (last_slot) state_q <= S_DONE;
          end
          s_q <= s_q + 8'd1;
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign chaos_ready = (state_q == S_COLLECT);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign perm_we     = we_q;
  assign perm_addr   = addr_q;
  assign perm_data   = data_q;
  assign fail        = fail_q;
  assign dup_count   = dup_q;
  assign draw_count  = draw_q;

endmodule
